// File: rtl/me_cfg_loader_pkg.sv
// Shared types and constants for the motion-estimator configuration loader.
package me_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } me_state_e;

  localparam int unsigned KEY_LOAD  = 0;
  localparam int unsigned KEY_CLEAR = 1;
  localparam int unsigned CFG_SEQ_W = 4;

endpackage

// File: rtl/me_cfg_loader_debounce.sv
// Single-key debouncer: accepts a level change only after DEBOUNCE_CYCLES
// consecutive differing samples and pulses press_out on a debounced 1->0 edge.
module debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic stable_out,
  output logic press_out
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             press_q, press_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (raw_in == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = raw_in;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Edge taken from the registered level so the pulse follows the accept by one cycle.
    press_d = stable_dly_q & ~stable_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      press_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= press_d;
    end
  end

  assign stable_out = stable_q;
  assign press_out  = press_q;

endmodule

// File: rtl/me_cfg_loader.sv
// Conditions switch/key inputs and turns KEY0 presses into valid/ready
// configuration transfers toward the motion estimator core.
module me_cfg_loader
  import me_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                 CYCLONEV_CLK_50,
  input  logic                 reset_reset_n,
  input  logic [9:0]           sw_in,
  input  logic [1:0]           key_in,
  input  logic [31:0]          param1_in,
  input  logic [31:0]          param2_in,
  input  logic [31:0]          param3_in,
  output logic [9:0]           sw_sync,
  output logic [1:0]           key_press,
  output logic                 cfg_valid,
  input  logic                 cfg_ready,
  output logic [31:0]          cfg_p1,
  output logic [31:0]          cfg_p2,
  output logic [31:0]          cfg_p3,
  output logic [CFG_SEQ_W-1:0] cfg_seq,
  output logic                 overrun
);

  logic [9:0] sw_meta_q, sw_sync_q;
  logic [1:0] key_meta_q, key_sync_q;
  // Debounced levels are not consumed here; only the press pulses drive the FSM.
  logic [1:0] key_level_unused;

  always_ff @(posedge CYCLONEV_CLK_50 or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      key_meta_q <= '1;
      key_sync_q <= '1;
    end else begin
      sw_meta_q  <= sw_in;
      sw_sync_q  <= sw_meta_q;
      key_meta_q <= key_in;
      key_sync_q <= key_meta_q;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_key
    debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk        (CYCLONEV_CLK_50),
      .rst_n      (reset_reset_n),
      .raw_in     (key_sync_q[k]),
      .stable_out (key_level_unused[k]),
      .press_out  (key_press[k])
    );
  end

  me_state_e            state_q, state_d;
  logic                 valid_q, valid_d;
  logic [31:0]          p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [CFG_SEQ_W-1:0] seq_q, seq_d;
  logic                 ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    p3_d    = p3_q;
    seq_d   = seq_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        // A clear in the same cycle as a load suppresses the load.
        if (key_press[KEY_CLEAR]) begin
          ovr_d = 1'b0;
        end else if (key_press[KEY_LOAD]) begin
          p1_d    = param1_in;
          p2_d    = param2_in;
          p3_d    = param3_in;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (key_press[KEY_CLEAR]) begin
          ovr_d = 1'b0;
        end else if (key_press[KEY_LOAD]) begin
          ovr_d = 1'b1;
        end
        // Ready takes precedence over an abort so a coinciding clear still completes.
        if (cfg_ready) begin
          valid_d = 1'b0;
          seq_d   = seq_q + 1'b1;
          state_d = IDLE;
        end else if (key_press[KEY_CLEAR]) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CYCLONEV_CLK_50 or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      p1_q    <= '0;
      p2_q    <= '0;
      p3_q    <= '0;
      seq_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      seq_q   <= seq_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sw_sync   = sw_sync_q;
  assign cfg_valid = valid_q;
  assign cfg_p1    = p1_q;
  assign cfg_p2    = p2_q;
  assign cfg_p3    = p3_q;
  assign cfg_seq   = seq_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_me_cfg_loader.sv
// Self-checking bench for me_cfg_loader: directed scenarios plus random
// stimulus, all compared every cycle against a behavioural model.
module tb_me_cfg_loader;

  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  sw_in = '0;
  logic [1:0]  key_in = 2'b11;
  logic [31:0] param1_in = '0, param2_in = '0, param3_in = '0;
  logic        cfg_ready = 1'b0;
  logic [9:0]  sw_sync;
  logic [1:0]  key_press;
  logic        cfg_valid;
  logic [31:0] cfg_p1, cfg_p2, cfg_p3;
  logic [3:0]  cfg_seq;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  me_cfg_loader #(.DEBOUNCE_CYCLES(DB)) dut (
    .CYCLONEV_CLK_50 (clk),
    .reset_reset_n   (rst_n),
    .sw_in           (sw_in),
    .key_in          (key_in),
    .param1_in       (param1_in),
    .param2_in       (param2_in),
    .param3_in       (param3_in),
    .sw_sync         (sw_sync),
    .key_press       (key_press),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_p1          (cfg_p1),
    .cfg_p2          (cfg_p2),
    .cfg_p3          (cfg_p3),
    .cfg_seq         (cfg_seq),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: expected output values after each rising edge.
  logic [9:0]  m_sw, sw_prev;
  logic [1:0]  m_kp, kp_pend, m_stable;
  logic        m_valid, m_ovr;
  logic [31:0] m_p1, m_p2, m_p3;
  int          m_seq;
  logic [1:0]  raw_q[$];
  logic [1:0]  lvl_q[$];

  task automatic model_reset();
    m_sw = '0; sw_prev = '0;
    m_kp = '0; kp_pend = '0; m_stable = 2'b11;
    m_valid = 1'b0; m_ovr = 1'b0;
    m_p1 = '0; m_p2 = '0; m_p3 = '0;
    m_seq = 0;
    raw_q.delete();
    raw_q.push_back(2'b11);
    raw_q.push_back(2'b11);
    lvl_q.delete();
  endtask

  task automatic model_step();
    logic [1:0] kp_now, lvl, fell, dummy;
    logic       all_diff;
    kp_now = m_kp;
    fell   = '0;
    if (!m_valid) begin
      if (kp_now[1]) m_ovr = 1'b0;
      else if (kp_now[0]) begin
        m_p1 = param1_in; m_p2 = param2_in; m_p3 = param3_in;
        m_valid = 1'b1;
      end
    end else begin
      if (kp_now[1]) m_ovr = 1'b0;
      else if (kp_now[0]) m_ovr = 1'b1;
      if (cfg_ready) begin
        m_valid = 1'b0;
        m_seq = (m_seq + 1) % 16;
      end else if (kp_now[1]) begin
        m_valid = 1'b0;
      end
    end
    m_kp = kp_pend;
    raw_q.push_back(key_in);
    lvl = raw_q.pop_front();
    lvl_q.push_back(lvl);
    if (lvl_q.size() > DB) dummy = lvl_q.pop_front();
    for (int i = 0; i < 2; i++) begin
      if (lvl_q.size() == DB) begin
        all_diff = 1'b1;
        foreach (lvl_q[j]) if (lvl_q[j][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_stable[i] = lvl[i];
          if (lvl[i] == 1'b0) fell[i] = 1'b1;
        end
      end
    end
    kp_pend = fell;
    m_sw = sw_prev;
    sw_prev = sw_in;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("sw_sync",   32'(sw_sync),   32'(m_sw));
      chk("key_press", 32'(key_press), 32'(m_kp));
      chk("cfg_valid", 32'(cfg_valid), 32'(m_valid));
      chk("cfg_p1",    cfg_p1,         m_p1);
      chk("cfg_p2",    cfg_p2,         m_p2);
      chk("cfg_p3",    cfg_p3,         m_p3);
      chk("cfg_seq",   32'(cfg_seq),   32'(m_seq));
      chk("overrun",   32'(overrun),   32'(m_ovr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int k);
    key_in[k] = 1'b0;
    tick(DB + 3);
  endtask

  task automatic release_key(input int k);
    key_in[k] = 1'b1;
    tick(DB + 4);
  endtask

  task automatic count_presses(input int k, input int n, output int pulses, output int first);
    pulses = 0;
    first  = 0;
    for (int c = 1; c <= n; c++) begin
      tick(1);
      if (key_press[k]) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
  endtask

  task automatic complete();
    cfg_ready = 1'b1;
    tick(1);
    cfg_ready = 1'b0;
  endtask

  initial begin
    int pulses, first, p0, f0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #6;
    chk("rst_sw_sync", 32'(sw_sync), 0);
    chk("rst_key_press", 32'(key_press), 0);
    chk("rst_cfg_valid", 32'(cfg_valid), 0);
    chk("rst_cfg_p123", cfg_p1 | cfg_p2 | cfg_p3, 0);
    chk("rst_cfg_seq", 32'(cfg_seq), 0);
    chk("rst_overrun", 32'(overrun), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick(2);

    // Load and handshake
    param1_in = 32'h11111111; param2_in = 32'h22222222; param3_in = 32'h33333333;
    press_key(0);
    chk("load_press_pulse", 32'(key_press), 1);
    tick(1);
    for (int c = 0; c < 10; c++) begin
      chk("load_valid_held", 32'(cfg_valid), 1);
      chk("load_p1", cfg_p1, 32'h11111111);
      chk("load_p3", cfg_p3, 32'h33333333);
      tick(1);
    end
    complete();
    chk("load_valid_drop", 32'(cfg_valid), 0);
    chk("load_seq", 32'(cfg_seq), 1);
    release_key(0);

    // Overrun
    press_key(0);
    tick(1);
    param1_in = 32'hDEADBEEF;
    release_key(0);
    press_key(0);
    tick(1);
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_p1_frozen", cfg_p1, 32'h11111111);
    release_key(0);
    complete();
    chk("ovr_seq", 32'(cfg_seq), 2);
    press_key(1);
    tick(1);
    chk("ovr_cleared", 32'(overrun), 0);
    release_key(1);

    // Abort versus completion
    press_key(0);
    tick(1);
    release_key(0);
    press_key(1);
    tick(1);
    chk("abort_valid", 32'(cfg_valid), 0);
    chk("abort_seq", 32'(cfg_seq), 2);
    chk("abort_ovr", 32'(overrun), 0);
    release_key(1);
    press_key(0);
    tick(1);
    release_key(0);
    press_key(1);
    complete();
    chk("clear_ready_valid", 32'(cfg_valid), 0);
    chk("clear_ready_seq", 32'(cfg_seq), 3);
    chk("clear_ready_ovr", 32'(overrun), 0);
    release_key(1);

    // Bounce rejection
    key_in[0] = 1'b0;
    count_presses(0, 5, p0, f0);
    key_in[0] = 1'b1;
    count_presses(0, 3, pulses, first);
    p0 += pulses;
    chk("bounce_glitch_pulses", p0, 0);
    key_in[0] = 1'b0;
    count_presses(0, 20, pulses, first);
    chk("bounce_pulses", pulses, 1);
    chk("bounce_latency", first, 11);
    key_in[0] = 1'b1;
    count_presses(0, 20, pulses, first);
    chk("release_pulses", pulses, 0);
    complete();
    chk("bounce_seq", 32'(cfg_seq), 4);

    // Sequence wrap
    for (int i = 0; i < 16; i++) begin
      press_key(0);
      tick(1);
      complete();
      if (i == 10) chk("wrap_seq15", 32'(cfg_seq), 15);
      if (i == 11) chk("wrap_seq0", 32'(cfg_seq), 0);
      release_key(0);
    end
    sw_in = 10'h2A5;
    tick(1);
    chk("sw_one_cycle", 32'(sw_sync), 0);
    tick(1);
    chk("sw_two_cycles", 32'(sw_sync), 32'h2A5);

    // Reset mid-HOLD
    press_key(0);
    tick(1);
    release_key(0);
    press_key(0);
    tick(1);
    chk("pre_rst_ovr", 32'(overrun), 1);
    key_in = 2'b11;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(cfg_valid), 0);
    chk("async_rst_ovr", 32'(overrun), 0);
    chk("async_rst_seq", 32'(cfg_seq), 0);
    chk("async_rst_p1", cfg_p1, 0);
    #2 rst_n = 1'b1;
    count_presses(0, 20, p0, f0);
    count_presses(1, 1, pulses, first);
    chk("post_rst_pulses", p0 + pulses, 0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) key_in[0] = ~key_in[0];
      if ($urandom_range(0, 13) == 0) key_in[1] = ~key_in[1];
      cfg_ready = ($urandom_range(0, 3) == 0);
      param1_in = $urandom;
      param2_in = $urandom;
      param3_in = $urandom;
      if ($urandom_range(0, 7) == 0) sw_in = 10'($urandom);
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
